oam_dma_arbiter: RTL and testbench
==================================

Name: oam_dma_arbiter

Overview:
- Sits between the sm83 core bus (addr/d_in/d_out/write) and the single-port system memory.
- Implements the OAM DMA engine. A CPU write to the DMA register starts a copy of XFER_LEN bytes from {src_hi, 8'h00} to OAM_BASE.
- While a transfer runs, it arbitrates the one memory port between the DMA engine and CPU accesses to HRAM.

Parameters:
- DMA_REG_ADDR, 16'hFF46, CPU-visible DMA source-high register address.
- OAM_BASE, 16'hFE00, destination base address.
- XFER_LEN, 160, bytes per transfer (1..256).
- START_DELAY, 1, idle clocks between the trigger write and the first DMA read (0..15).
- HRAM_LO, 16'hFF80, first HRAM address.
- HRAM_HI, 16'hFFFE, last HRAM address.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- cpu_addr  in  16  CPU address.
- cpu_d_out  in  8  CPU write data.
- cpu_write  in  1  CPU write strobe.
- cpu_d_in  out  8  read data returned to CPU (combinational).
- mem_addr  out  16  memory address (combinational).
- mem_d_out  out  8  memory write data.
- mem_write  out  1  memory write strobe.
- mem_d_in  in  8  memory read data; valid before the next posedge for the address driven this cycle.
- dma_active  out  1  high in DELAY/READ/WRITE.

Behaviour:
- Reset: sampled at posedge with rst==0. Clears state=IDLE, idx=0, src_hi=8'h00, buf=8'h00.
  - Outputs after reset: dma_active=0. Memory outputs pass CPU signals through.
- Register access:
  - CPU write to DMA_REG_ADDR latches src_hi and is not forwarded (mem_write=0).
  - CPU read of DMA_REG_ADDR returns src_hi.
- Address classes: cpu_hram = HRAM_LO <= cpu_addr <= HRAM_HI; cpu_reg = (cpu_addr == DMA_REG_ADDR).
- FSM states: IDLE, DELAY, READ, WRITE.
- IDLE:
  - Bus passes through: mem_addr=cpu_addr, mem_d_out=cpu_d_out, mem_write=cpu_write & ~cpu_reg, cpu_d_in=mem_d_in (src_hi when cpu_reg).
  - A trigger write goes to DELAY with cnt=START_DELAY-1, or directly to READ when START_DELAY==0. idx=0.
- DELAY:
  - Pass-through bus, as in IDLE.
  - cnt decrements each clock; at 0 -> READ.
- READ and WRITE (DMA owns the port unless the CPU accesses HRAM):
  - READ drives mem_addr={src_hi, idx}, mem_write=0. At posedge, buf<=mem_d_in and state -> WRITE.
  - WRITE drives mem_addr=OAM_BASE+idx, mem_d_out=buf, mem_write=1. At posedge, if idx==XFER_LEN-1 -> IDLE, else idx++ and -> READ.
  - Each byte costs 2 clocks; a full transfer with no stalls takes 2*XFER_LEN clocks after DELAY.
- CPU accesses while DMA is in READ or WRITE:
  - cpu_hram: the CPU gets the port (pass-through). The DMA state, idx and buf hold that cycle (stall, no data lost).
  - cpu_reg: serviced by the register. The DMA proceeds, since memory is untouched.
  - Anything else: the DMA keeps the port. cpu_d_in=8'hFF and CPU writes are dropped.
- Trigger while dma_active: behaviour is set by the optional feature below.
- src_hi is used verbatim; there is no echo-RAM remapping.
- idx is 8 bits; XFER_LEN=256 ends at idx==255 without wrap.
- Reset mid-transfer: aborts immediately. The next cycle is IDLE pass-through; partial OAM contents remain.

Optional Feature:
- Macro: OAM_DMA_RESTART_EN.
- Defined: a trigger write during DELAY/READ/WRITE relatches src_hi, sets idx=0 and re-enters DELAY (or READ when START_DELAY==0). The in-flight byte is discarded.
- Undefined: the trigger write still updates src_hi for readback. The transfer in flight continues with its original source high byte, latched at start into a separate cur_hi register.

Decomposition:
- Shared package sm83_bus_pkg holds:
  - typedef enum logic [1:0] dma_state_t {IDLE, DELAY, READ, WRITE};
  - localparams for the DMA register, OAM and HRAM addresses, reused by the top and the bench.
- One natural sub-module, oam_dma_engine, containing the FSM, counters and buf, exposing dma_addr, dma_write, dma_data and a stall input.
- The top-level mux/arbiter logic stays in oam_dma_arbiter.

Test Plan:
- Pass-through: rst low 1 clk, then CPU reads 16'h0123 holding 8'hA5 -> cpu_d_in=8'hA5 and dma_active=0. CPU write of 8'h3C to 16'hC000 -> mem[16'hC000]=8'h3C.
- Full DMA: preload mem[16'hC000+i]=i. CPU writes 8'hC0 to 16'hFF46. dma_active rises the next clock, and after 1+320 clocks mem[16'hFE00+i]==i for i=0..159 and dma_active=0. A read of 16'hFF46 returns 8'hC0.
- Blocking: during DMA, CPU reads 16'hC010 -> 8'hFF. CPU writes 8'h77 to 16'hD000 -> mem[16'hD000] unchanged.
- HRAM stall: during DMA, CPU writes 8'h5A to 16'hFF90 on 4 consecutive clocks. mem[16'hFF90]=8'h5A, the transfer completes 4 clocks later than the unstalled run, and OAM contents are still correct.
- Reset mid-transfer: rst low at byte 50 -> next cycle dma_active=0 and pass-through is active. OAM bytes 0..49 are copied; bytes 50..159 are unchanged.
- Retrigger at byte 80 with 8'hD0:
  - With OAM_DMA_RESTART_EN: OAM ends holding mem[16'hD000..16'hD09F].
  - Without it: OAM holds the C0 source data and 16'hFF46 reads 8'hD0.

Source files
------------

// File: rtl/sm83_bus_pkg.sv
// sm83_bus_pkg
//   Shared definitions for the SM83 system bus: the OAM DMA state encoding
//   and the default addresses of the DMA register, OAM and HRAM. These are
//   used by oam_dma_arbiter, oam_dma_engine and the bench.
package sm83_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } dma_state_t;

    localparam logic [15:0] SM83_DMA_REG  = 16'hFF46;
    localparam logic [15:0] SM83_OAM_BASE = 16'hFE00;
    localparam logic [15:0] SM83_HRAM_LO  = 16'hFF80;
    localparam logic [15:0] SM83_HRAM_HI  = 16'hFFFE;
    localparam int          OAM_XFER_LEN  = 160;

endpackage

// File: rtl/oam_dma_engine.sv
// oam_dma_engine
//   OAM DMA sequencer: start delay, then alternating READ/WRITE clocks that
//   copy XFER_LEN bytes from {cur_hi, idx} to OAM_BASE + idx.
//   Optional feature macro: OAM_DMA_RESTART_EN. When defined, a start
//   request during an active transfer restarts it from the new source page.
//   When undefined, such a request is ignored by the engine and the transfer
//   in flight keeps its original source page held in cur_hi.
// Ports:
//   clk, rst      system clock; synchronous active-low reset
//   start         CPU write to the DMA register this cycle
//   start_hi      source high byte written by the CPU
//   stall         CPU holds the memory port this cycle (HRAM access)
//   mem_rdata     memory read data for the address driven this cycle
//   dma_active    high in DELAY/READ/WRITE (registered)
//   dma_req       engine wants the memory port (READ/WRITE)
//   dma_addr      address the engine drives when it owns the port
//   dma_write     write strobe the engine drives when it owns the port
//   dma_data      write data (byte fetched by the last READ)
module oam_dma_engine
    import sm83_bus_pkg::*;
#(
    parameter logic [15:0] OAM_BASE    = SM83_OAM_BASE,
    parameter int          XFER_LEN    = OAM_XFER_LEN,
    parameter int          START_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  start_hi,
    input  logic        stall,
    input  logic [7:0]  mem_rdata,
    output logic        dma_active,
    output logic        dma_req,
    output logic [15:0] dma_addr,
    output logic        dma_write,
    output logic [7:0]  dma_data
);

    localparam logic [7:0] LAST_IDX    = 8'(XFER_LEN - 1);
    localparam logic [3:0] DELAY_INIT  = 4'((START_DELAY == 0) ? 0 : START_DELAY - 1);
    localparam dma_state_t START_STATE = (START_DELAY == 0) ? READ : DELAY;

    dma_state_t state;
    logic [7:0] idx;
    logic [3:0] cnt;
    logic [7:0] cur_hi;
    logic [7:0] data_buf;
    logic       accept;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        accept = 1'b0;
`ifdef OAM_DMA_RESTART_EN
        accept = start;
`else
        accept = start && (state == IDLE);
`endif
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= 8'h00;
            cnt        <= 4'h0;
            cur_hi     <= 8'h00;
            data_buf   <= 8'h00;
            dma_active <= 1'b0;
        end else if (accept) begin
            // A restart discards any byte in flight; idx starts over.
            state      <= START_STATE;
            idx        <= 8'h00;
            cnt        <= DELAY_INIT;
            cur_hi     <= start_hi;
            dma_active <= 1'b1;
        end else begin
            case (state)
                IDLE: ;
                DELAY: begin
                    if (cnt == 4'h0) state <= READ;
                    else             cnt   <= cnt - 4'h1;
                end
                READ: begin
                    if (!stall) begin
                        data_buf <= mem_rdata;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (!stall) begin
                        // idx never wraps: a 256-byte transfer ends at 255.
                        if (idx == LAST_IDX) begin
                            state      <= IDLE;
                            dma_active <= 1'b0;
                        end else begin
                            idx   <= idx + 8'h01;
                            state <= READ;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    dma_active <= 1'b0;
                end
            endcase
        end
    end

    assign dma_req   = (state == READ) || (state == WRITE);
    assign dma_write = (state == WRITE);
    assign dma_addr  = (state == READ) ? {cur_hi, idx} : (OAM_BASE + {8'h00, idx});
    assign dma_data  = data_buf;

endmodule

// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter
//   Sits between the SM83 core bus and single-port system memory. Hosts the
//   CPU-visible DMA source register and arbitrates the memory port between
//   the CPU and oam_dma_engine. While the engine is in READ/WRITE, CPU HRAM
//   accesses win (and stall the engine), register accesses are serviced
//   locally, and all other CPU accesses are blocked (reads return 8'hFF).
//   Optional feature macro: OAM_DMA_RESTART_EN (see oam_dma_engine).
// Ports:
//   clk, rst               system clock; synchronous active-low reset
//   cpu_addr/cpu_d_out     CPU address and write data
//   cpu_write              CPU write strobe
//   cpu_d_in               read data to CPU (combinational)
//   mem_addr/mem_d_out     memory address (combinational) and write data
//   mem_write              memory write strobe
//   mem_d_in               memory read data for the address driven this cycle
//   dma_active             transfer in progress (DELAY/READ/WRITE)
module oam_dma_arbiter
    import sm83_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = SM83_DMA_REG,
    parameter logic [15:0] OAM_BASE     = SM83_OAM_BASE,
    parameter int          XFER_LEN     = OAM_XFER_LEN,
    parameter int          START_DELAY  = 1,
    parameter logic [15:0] HRAM_LO      = SM83_HRAM_LO,
    parameter logic [15:0] HRAM_HI      = SM83_HRAM_HI
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_write,
    output logic [7:0]  cpu_d_in,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_d_out,
    output logic        mem_write,
    input  logic [7:0]  mem_d_in,
    output logic        dma_active
);

    logic        cpu_hram;
    logic        cpu_reg;
    logic        trigger;
    logic [7:0]  src_hi;
    logic        dma_req;
    logic        dma_owns;
    logic [15:0] dma_addr;
    logic        dma_write;
    logic [7:0]  dma_data;

    assign cpu_hram = (cpu_addr >= HRAM_LO) && (cpu_addr <= HRAM_HI);
    assign cpu_reg  = (cpu_addr == DMA_REG_ADDR);
    assign trigger  = cpu_write && cpu_reg;
    assign dma_owns = dma_req && !cpu_hram;

    // Readback copy of the source page; always follows the latest CPU write,
    // even when the engine keeps its own copy for the transfer in flight.
    always_ff @(posedge clk) begin
        if (!rst)         src_hi <= 8'h00;
        else if (trigger) src_hi <= cpu_d_out;
    end

    oam_dma_engine #(
        .OAM_BASE    (OAM_BASE),
        .XFER_LEN    (XFER_LEN),
        .START_DELAY (START_DELAY)
    ) u_engine (
        .clk        (clk),
        .rst        (rst),
        .start      (trigger),
        .start_hi   (cpu_d_out),
        .stall      (cpu_hram),
        .mem_rdata  (mem_d_in),
        .dma_active (dma_active),
        .dma_req    (dma_req),
        .dma_addr   (dma_addr),
        .dma_write  (dma_write),
        .dma_data   (dma_data)
    );

    always_comb begin
        mem_addr  = cpu_addr;
        mem_d_out = cpu_d_out;
        mem_write = cpu_write && !cpu_reg;
        cpu_d_in  = cpu_reg ? src_hi : mem_d_in;
        if (dma_owns) begin
            mem_addr  = dma_addr;
            mem_d_out = dma_data;
            mem_write = dma_write;
            cpu_d_in  = cpu_reg ? src_hi : 8'hFF;
        end
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb_oam_dma_arbiter
//   Directed bench for oam_dma_arbiter with a behavioural single-port memory.
//   Inputs change on the falling edge; outputs are checked shortly after.
module tb_oam_dma_arbiter;
    import sm83_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_d_out;
    logic        cpu_write;
    logic [7:0]  cpu_d_in;
    logic [15:0] mem_addr;
    logic [7:0]  mem_d_out;
    logic        mem_write;
    logic [7:0]  mem_d_in;
    logic        dma_active;

    logic [7:0]  mem [0:65535];
    logic        tb_we;
    logic [15:0] tb_wa;
    logic [7:0]  tb_wd;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    oam_dma_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_d_out  (cpu_d_out),
        .cpu_write  (cpu_write),
        .cpu_d_in   (cpu_d_in),
        .mem_addr   (mem_addr),
        .mem_d_out  (mem_d_out),
        .mem_write  (mem_write),
        .mem_d_in   (mem_d_in),
        .dma_active (dma_active)
    );

    // Memory: a bench-side port used only while the DUT is idle for preloads.
    always @(posedge clk) begin
        if (tb_we)          mem[tb_wa]    <= tb_wd;
        else if (mem_write) mem[mem_addr] <= mem_d_out;
    end
    assign mem_d_in = mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic cpu_idle();
        cpu_addr = 16'h0000; cpu_d_out = 8'h00; cpu_write = 1'b0;
    endtask

    task automatic fill_oam();
        for (int i = 0; i < 160; i++) poke(16'hFE00 + 16'(i), 8'hEE);
    endtask

    // Drive the trigger write; cyc counts clock edges after the trigger edge.
    task automatic trigger(input logic [7:0] hi);
        cpu_addr = 16'hFF46; cpu_d_out = hi; cpu_write = 1'b1;
        #1 check("trig_no_fwd", mem_write, 1'b0);
        @(negedge clk);
        cyc = 0;
        cpu_idle();
    endtask

    task automatic wait_idle();
        while (dma_active && cyc < 2000) step();
    endtask

    task automatic check_oam_src(input string tag, input logic [15:0] src);
        for (int i = 0; i < 160; i++)
            check($sformatf("%s[%0d]", tag, i), mem[16'hFE00 + 16'(i)], mem[src + 16'(i)]);
    endtask

    initial begin
        tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
        cpu_idle();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1 check("reset_active", dma_active, 1'b0);

        // Pass-through read and write.
        poke(16'h0123, 8'hA5);
        cpu_addr = 16'h0123;
        #1 check("pt_read", cpu_d_in, 8'hA5);
        check("pt_active", dma_active, 1'b0);
        check("pt_addr", mem_addr, 16'h0123);
        @(negedge clk);
        cpu_addr = 16'hC000; cpu_d_out = 8'h3C; cpu_write = 1'b1;
        @(negedge clk);
        cpu_idle();
        check("pt_write", mem[16'hC000], 8'h3C);
        cpu_addr = SM83_DMA_REG;
        #1 check("reg_reset", cpu_d_in, 8'h00);

        // Source data: C000+i = i, D000+i = i ^ 8'h5A.
        for (int i = 0; i < 160; i++) begin
            poke(16'hC000 + 16'(i), 8'(i));
            poke(16'hD000 + 16'(i), 8'(i) ^ 8'h5A);
        end
        fill_oam();

        // Full transfer: 1 delay clock + 2 clocks per byte.
        trigger(8'hC0);
        check("full_rise", dma_active, 1'b1);
        wait_idle();
        check("full_cycles", cyc, 321);
        check("full_done", dma_active, 1'b0);
        check_oam_src("full_oam", 16'hC000);
        cpu_addr = 16'hFF46;
        #1 check("full_reg", cpu_d_in, 8'hC0);
        @(negedge clk);
        cpu_idle();

        // Blocked CPU accesses do not stall the transfer.
        fill_oam();
        trigger(8'hC0);
        repeat (10) step();
        cpu_addr = 16'hC010;
        #1 check("blk_read", cpu_d_in, 8'hFF);
        step();
        cpu_addr = 16'hD000; cpu_d_out = 8'h77; cpu_write = 1'b1;
        step();
        cpu_idle();
        wait_idle();
        check("blk_write", mem[16'hD000], 8'h5A);
        check("blk_cycles", cyc, 321);
        check_oam_src("blk_oam", 16'hC000);

        // HRAM accesses stall the engine for four clocks.
        fill_oam();
        trigger(8'hC0);
        repeat (21) step();
        cpu_addr = 16'hFF90; cpu_d_out = 8'h5A; cpu_write = 1'b1;
        repeat (4) step();
        cpu_idle();
        wait_idle();
        check("hram_write", mem[16'hFF90], 8'h5A);
        check("hram_cycles", cyc, 325);
        check_oam_src("hram_oam", 16'hC000);

        // Reset while byte 50 is being read.
        fill_oam();
        trigger(8'hC0);
        while (cyc < 101) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        cpu_addr = 16'h0123;
        #1 check("rst_active", dma_active, 1'b0);
        check("rst_pt_read", cpu_d_in, 8'hA5);
        check("rst_pt_addr", mem_addr, 16'h0123);
        repeat (4) step();
        cpu_idle();
        check("rst_still_idle", dma_active, 1'b0);
        for (int i = 0; i < 160; i++)
            check($sformatf("rst_oam[%0d]", i), mem[16'hFE00 + 16'(i)],
                  (i < 50) ? 8'(i) : 8'hEE);

        // Retrigger with page D0 while byte 80 is about to be read.
        fill_oam();
        trigger(8'hC0);
        while (cyc < 161) step();
        cpu_addr = 16'hFF46; cpu_d_out = 8'hD0; cpu_write = 1'b1;
        step();
        cpu_idle();
        wait_idle();
        check("rtg_done", dma_active, 1'b0);
`ifdef OAM_DMA_RESTART_EN
        check("rtg_cycles", cyc, 483);
        check_oam_src("rtg_oam", 16'hD000);
`else
        check("rtg_cycles", cyc, 321);
        check_oam_src("rtg_oam", 16'hC000);
`endif
        cpu_addr = 16'hFF46;
        #1 check("rtg_reg", cpu_d_in, 8'hD0);
        @(negedge clk);
        cpu_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
